// File: rtl/serial_compare_ctrl.sv
// serial_compare_ctrl: bit-serial MSB-first unsigned compare of two WIDTH-bit operands through one
// 1-bit equality cell, stopping at the first mismatching bit.
module comparator_2b (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = ~(a ^ b);
endmodule

module serial_compare_ctrl #(
    parameter int WIDTH = 8,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt,
    output logic [CW-1:0]    bit_count
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;
    logic             a_bit, b_bit, match;

    assign a_bit = a_q[idx_q];
    assign b_bit = b_q[idx_q];

    comparator_2b u_cell (.a(a_bit), .b(b_bit), .y(match));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        case (state_q)
            IDLE: if (start) begin
                a_d     = a;
                b_d     = b;
                idx_d   = IW'(WIDTH - 1);
                cnt_d   = '0;
                eq_d    = 1'b0;
                gt_d    = 1'b0;
                lt_d    = 1'b0;
                state_d = RUN;
            end
            RUN: begin
                cnt_d = cnt_q + CW'(1);
                if (!match) begin
                    gt_d    = a_bit;
                    lt_d    = ~a_bit;
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    eq_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign eq        = eq_q;
    assign gt        = gt_q;
    assign lt        = lt_q;
    assign bit_count = cnt_q;
endmodule

// File: tb/tb_serial_compare_ctrl.sv
// tb_serial_compare_ctrl: directed self-checking bench for serial_compare_ctrl at WIDTH=8.
module tb_serial_compare_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       busy, done, eq, gt, lt;
    logic [3:0] bit_count;
    int         checks = 0, failures = 0;
    int         cyc = 0;

    serial_compare_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .eq(eq), .gt(gt), .lt(lt), .bit_count(bit_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulses start for one cycle, then counts busy cycles until done; optionally scrambles inputs meanwhile.
    task automatic run_cmp(input logic [7:0] va, input logic [7:0] vb, input bit scramble,
                           output int nbusy, output bit got_done);
        nbusy = 0;
        got_done = 0;
        @(negedge clk);
        a = va;
        b = vb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                got_done = 1;
                break;
            end
            if (busy) nbusy++;
            else break;
            if (scramble) begin
                a = 8'($urandom);
                b = 8'($urandom);
                start = ~start;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        int nb;
        bit gd;
        run_cmp(8'h80, 8'h7F, 0, nb, gd);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (gt !== 1'b1 || bit_count !== 4'd1) begin
            failures++;
            $display("FAIL reset_precond gt=%b bit_count=%0d required gt=1 bit_count=1", gt, bit_count);
        end
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, eq, gt, lt, bit_count} !== 9'b0) begin
            failures++;
            $display("FAIL reset_async outs=%b required 0", {busy, done, eq, gt, lt, bit_count});
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, eq, gt, lt, bit_count} !== 9'b0) begin
            failures++;
            $display("FAIL reset_idle outs=%b required 0", {busy, done, eq, gt, lt, bit_count});
        end
    endtask

    task automatic test_equal;
        int nb;
        bit gd;
        run_cmp(8'hA5, 8'hA5, 0, nb, gd);
        checks++;
        if (!gd || nb !== 8) begin
            failures++;
            $display("FAIL equal_timing done=%b busy_cycles=%0d required done=1 busy_cycles=8", gd, nb);
        end
        checks++;
        if ({eq, gt, lt} !== 3'b100 || bit_count !== 4'd8) begin
            failures++;
            $display("FAIL equal_result eqgtlt=%b bit_count=%0d required 100 8", {eq, gt, lt}, bit_count);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || eq !== 1'b1) begin
            failures++;
            $display("FAIL equal_hold done=%b busy=%b eq=%b required 0 0 1", done, busy, eq);
        end
    endtask

    task automatic test_gt_msb;
        int nb;
        bit gd;
        run_cmp(8'h80, 8'h7F, 0, nb, gd);
        checks++;
        if (!gd || nb !== 1) begin
            failures++;
            $display("FAIL gt_timing done=%b busy_cycles=%0d required done=1 busy_cycles=1", gd, nb);
        end
        checks++;
        if ({eq, gt, lt} !== 3'b010 || bit_count !== 4'd1) begin
            failures++;
            $display("FAIL gt_result eqgtlt=%b bit_count=%0d required 010 1", {eq, gt, lt}, bit_count);
        end
    endtask

    task automatic test_lt_toggle;
        int nb;
        bit gd;
        run_cmp(8'h12, 8'h13, 1, nb, gd);
        checks++;
        if (!gd || nb !== 8) begin
            failures++;
            $display("FAIL lt_timing done=%b busy_cycles=%0d required done=1 busy_cycles=8", gd, nb);
        end
        checks++;
        if ({eq, gt, lt} !== 3'b001 || bit_count !== 4'd8) begin
            failures++;
            $display("FAIL lt_result eqgtlt=%b bit_count=%0d required 001 8", {eq, gt, lt}, bit_count);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run;
        int nb;
        bit gd, saw_done;
        @(negedge clk);
        a = 8'hFF;
        b = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nb = 0;
        for (int i = 0; i < 20 && nb < 4; i++) begin
            if (busy) nb++;
            if (nb < 4) @(negedge clk);
        end
        checks++;
        if (nb !== 4) begin
            failures++;
            $display("FAIL midrun_busy busy_cycles=%0d required 4", nb);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, eq, gt, lt, bit_count} !== 9'b0) begin
            failures++;
            $display("FAIL midrun_reset outs=%b required 0", {busy, done, eq, gt, lt, bit_count});
        end
        @(negedge clk);
        reset = 1'b0;
        saw_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            failures++;
            $display("FAIL midrun_no_done activity=%b required 0", saw_done);
        end
        run_cmp(8'h40, 8'h20, 0, nb, gd);
        checks++;
        if (!gd || nb !== 2 || {eq, gt, lt} !== 3'b010 || bit_count !== 4'd2) begin
            failures++;
            $display("FAIL midrun_restart done=%b busy=%0d eqgtlt=%b bit_count=%0d required 1 2 010 2",
                     gd, nb, {eq, gt, lt}, bit_count);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int ndone = 0, last = 0;
        @(negedge clk);
        a = 8'h00;
        b = 8'h00;
        start = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (done) begin
                checks++;
                if (eq !== 1'b1 || bit_count !== 4'd8) begin
                    failures++;
                    $display("FAIL b2b_result eq=%b bit_count=%0d required 1 8", eq, bit_count);
                end
                if (ndone > 0) begin
                    checks++;
                    if (cyc - last !== 10) begin
                        failures++;
                        $display("FAIL b2b_period period=%0d required 10", cyc - last);
                    end
                end
                last = cyc;
                ndone++;
            end
        end
        start = 1'b0;
        checks++;
        if (ndone !== 3) begin
            failures++;
            $display("FAIL b2b_count dones=%0d required 3", ndone);
        end
        for (int i = 0; i < 12; i++) @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        test_reset;
        test_equal;
        test_gt_msb;
        test_lt_toggle;
        test_reset_mid_run;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
